// File: rtl/edge_delay_generate_if.sv
// edge_delay_generate_if: control inputs and status outputs of the edge-delay pulse generator
interface edge_delay_generate_if #(parameter int WIDTH = 4);
  logic             enable;
  logic [WIDTH-1:0] delay_value;
  logic [WIDTH-1:0] hold_value;
  logic             trigger;
  logic             output_value;
  logic             busy;
  logic             done;
  logic             trigger_drop;
  modport master (output enable, delay_value, hold_value, trigger,
                  input  output_value, busy, done, trigger_drop);
  modport slave  (input  enable, delay_value, hold_value, trigger,
                  output output_value, busy, done, trigger_drop);
endinterface

// File: rtl/edge_delay_generate.sv
// edge_delay_generate: triggered pulse with programmable assert delay, active width and recovery gap
module edge_delay_generate #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  edge_delay_generate_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, RECOVER} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, d_q, d_d, h_q, h_d;
  logic             out_q, out_d, done_q, done_d, drop_q, drop_d;
  logic             d_last;
  assign d_last = cnt_q == d_q - WIDTH'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    h_d     = h_q;
    out_d   = out_q;
    done_d  = 1'b0;
    drop_d  = bus.trigger && !(state_q == IDLE && bus.enable);
    case (state_q)
      IDLE: if (bus.trigger && bus.enable) begin
        d_d     = bus.delay_value;
        h_d     = bus.hold_value;
        cnt_d   = '0;
        state_d = bus.delay_value == '0 ? ACTIVE : DELAY;
        out_d   = bus.delay_value == '0 ? ~IDLE_LEVEL : IDLE_LEVEL;
      end
      DELAY: if (d_last) begin
        state_d = ACTIVE;
        cnt_d   = '0;
        out_d   = ~IDLE_LEVEL;
      end else cnt_d = cnt_q + WIDTH'(1);
      ACTIVE: if (cnt_q == h_q) begin
        state_d = d_q == '0 ? IDLE : RECOVER;
        cnt_d   = '0;
        out_d   = IDLE_LEVEL;
        done_d  = 1'b1;
      end else cnt_d = cnt_q + WIDTH'(1);
      RECOVER: if (d_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + WIDTH'(1);
      default: state_d = IDLE;
    endcase
    // dropping enable abandons the pulse without signalling completion
    if (state_q != IDLE && !bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      out_d   = IDLE_LEVEL;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      h_q     <= '0;
      out_q   <= IDLE_LEVEL;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      h_q     <= h_d;
      out_q   <= out_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end
  assign bus.output_value = out_q;
  assign bus.busy         = state_q != IDLE;
  assign bus.done         = done_q;
  assign bus.trigger_drop = drop_q;
endmodule

// File: tb/tb_edge_delay_generate.sv
// tb_edge_delay_generate: vector table of pulses plus corner sequences, checked through a scoreboard queue
module tb_edge_delay_generate;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  edge_delay_generate_if #(.WIDTH(4)) b0 ();
  edge_delay_generate_if #(.WIDTH(4)) b1 ();
  edge_delay_generate #(.WIDTH(4), .IDLE_LEVEL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  edge_delay_generate #(.WIDTH(4), .IDLE_LEVEL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  assign b1.enable      = b0.enable;
  assign b1.delay_value = b0.delay_value;
  assign b1.hold_value  = b0.hold_value;
  assign b1.trigger     = b0.trigger;
  typedef struct {logic o; logic b; logic d; logic t;} exp_t;
  typedef struct {int d; int h; int gap; int tk2; int kk; int kind;} vec_t;
  exp_t q[$];
  vec_t tv[14];
  int   checks = 0;
  int   errors = 0;
  task automatic chk(input string n, input logic a, input logic x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", n, $time, a, x);
    end
  endtask
  task automatic step(input logic trg, input logic en, input logic r,
                      input logic o, input logic bz, input logic dn, input logic dr);
    exp_t e;
    b0.trigger = trg;
    b0.enable  = en;
    rst        = r;
    q.push_back('{o, bz, dn, dr});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("out_idle0", b0.output_value, e.o);
    chk("out_idle1", b1.output_value, ~e.o);
    chk("busy0", b0.busy, e.b);
    chk("busy1", b1.busy, e.b);
    chk("done0", b0.done, e.d);
    chk("done1", b1.done, e.d);
    chk("drop0", b0.trigger_drop, e.t);
    chk("drop1", b1.trigger_drop, e.t);
  endtask
  initial begin
    // d, h, gap after pulse, k of a second (dropped) trigger, k of abort, abort kind (1 enable, 2 reset)
    tv = '{'{3, 2, 2, -1, -1, 0}, '{0, 0, 0, -1, -1, 0}, '{0, 0, 0, -1, -1, 0},
           '{0, 0, 1, -1, -1, 0}, '{2, 4, 1, 4, -1, 0},  '{5, 7, 1, -1, 8, 1},
           '{5, 7, 0, -1, 7, 2},  '{3, 2, 1, -1, -1, 0}, '{4, 2, 1, -1, 2, 1},
           '{2, 1, 1, -1, 5, 1},  '{15, 15, 2, 20, -1, 0}, '{1, 0, 0, -1, -1, 0},
           '{0, 3, 1, 2, -1, 0},  '{4, 0, 1, -1, -1, 0}};
    b0.delay_value = '0;
    b0.hold_value  = '0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (tv[i]) begin
      automatic vec_t v    = tv[i];
      automatic int   last = v.kk >= 0 ? v.kk : 2 * v.d + v.h + 1;
      b0.delay_value = 4'(v.d);
      b0.hold_value  = 4'(v.h);
      for (int k = 0; k <= last; k++) begin
        automatic logic kill = v.kk >= 0 && k >= v.kk;
        step(k == 0 || k == v.tk2, !(v.kind == 1 && k == v.kk), v.kind == 2 && k == v.kk,
             !kill && k >= v.d && k <= v.d + v.h, !kill && k < 2 * v.d + v.h + 1,
             !kill && k == v.d + v.h + 1, k == v.tk2);
        b0.delay_value = 4'($urandom);
        b0.hold_value  = 4'($urandom);
      end
      for (int g = 0; g < v.gap; g++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
